traffic_phase_controller: RTL
=============================

Name: traffic_phase_controller

Overview:
- Sequencer side of the junction lamp interface. Arbitrates road service from vehicle sensors a, b, c and d (roads 1 to 4), times the green, yellow and clearance intervals, and drives the encoded `state` / `next_state` buses.
- The `lights` lamp decoder consumes those buses and produces r/g/y per road.
- Contains no lamp decoding itself.

Parameters:
- GREEN_MIN, 4: minimum green ticks once green is entered.
- GREEN_MAX, 10: maximum green ticks while any other road has demand.
- YELLOW_T, 2: yellow duration in ticks.
- CLEAR_T, 1: all-red clearance duration in ticks.
- TIMER_W, 8: phase timer width. Must hold GREEN_MAX; elaboration fails if GREEN_MIN > GREEN_MAX or any duration is 0.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- tick_en  in  1  timebase enable. Timers advance only on clk edges where this is 1.
- a  in  1  road 1 vehicle sensor, level, synchronous to clk.
- b  in  1  road 2 vehicle sensor.
- c  in  1  road 3 vehicle sensor.
- d  in  1  road 4 vehicle sensor.
- state  out  4  current phase code, registered.
- next_state  out  4  phase to be entered at the next transition; combinational from registers and sensors.
- phase_done  out  1  one-clk pulse, registered, on every phase transition.

Behaviour:
- Phase codes: 0 ALL_RED, 1 G1, 2 Y1, 3 G2, 4 Y2, 5 G3, 6 Y3, 7 G4, 8 Y4. Codes 9 to 15 are illegal; if reached, recover to ALL_RED on the next clk.
- Reset (async assert, sync release):
  - state=0, phase_done=0, timer=0, demand=4'b0000.
  - last_served=4, so the first search order is 1, 2, 3, 4.
- Timer:
  - Counts tick_en edges spent in the current phase.
  - Clears to 0 on transition.
  - Saturates at all-ones.
  - A transition happens only on a clk edge where tick_en=1 and the exit condition holds.
- Exit conditions (timer value before the increment):
  - Gi: leave when the other-road demand OR is true, AND either (timer >= GREEN_MAX-1) or (timer >= GREEN_MIN-1 and own sensor is 0).
  - Gi with no other demand: rest on green indefinitely.
  - Yi: timer == YELLOW_T-1, then ALL_RED.
  - ALL_RED: timer == CLEAR_T-1. Target is G of the first road with demand, searching round-robin from last_served+1.
  - ALL_RED with no demand: target is road last_served+1 (wraps 4 to 1).
- Resulting phase lengths: Yi lasts exactly YELLOW_T ticks, ALL_RED exactly CLEAR_T ticks, and Gi at least GREEN_MIN ticks.
- Demand latch:
  - demand[i] is set on any clk where sensor i=1.
  - It is cleared on the edge entering Gi and held 0 throughout Gi. Clear wins over a simultaneous set.
  - A sensor seen during Yi or ALL_RED sets demand.
- last_served updates to i on entry to Gi.
- next_state:
  - Gi gives Yi; Yi gives ALL_RED; ALL_RED gives the arbitrated Gj.
  - Valid every cycle; tracks sensor changes combinationally while in ALL_RED.
  - state always takes the current next_state value at transition.
- phase_done is 1 for exactly one clk after each transition edge.
- tick_en=0 freezes the timer and state. Demand latching continues.
- Reset asserted mid-phase: outputs go to their reset values immediately, with no wait for a clock edge.

Decomposition:
- Shared package:
  - Phase code localparams: PH_ALL_RED, PH_G1 … PH_Y4.
  - ROADS=4.
  - Road index type (2-bit), phase type (4-bit).
- `lights` and this block both import the package.
- One natural sub-module: `rr_road_arbiter`. Combinational, 4-bit demand plus last_served in, 2-bit winner and any_demand out.

Test Plan:
(GREEN_MIN=4, GREEN_MAX=10, YELLOW_T=2, CLEAR_T=1, tick_en=1 unless stated.)
1. Reset release with all sensors 0 -> state 0 for 1 clk, then state=1 (G1) and held for 50 clks; phase_done pulses once.
2. In G1 with a=0, pulse c for 1 clk at timer=1 -> G1 total 4 ticks, Y1 (2) 2 ticks, ALL_RED 1 tick, then G3 (5), skipping road 2. next_state=5 throughout ALL_RED.
3. In G1 with a held 1, pulse b once -> G1 lasts exactly 10 ticks, then Y1, ALL_RED, G2.
4. a, b, c, d all held 1 from reset -> green order G1, G2, G3, G4, G1; each green 10 ticks, each cycle 52 ticks.
5. tick_en toggling 1 clk on / 3 clks off in Y2 -> Y2 spans 8 clks; state and timer constant on off-clks; demand still latches a pulse on d.
6. rst_n low for 1 clk mid-Y2 with demand=4'b1010 -> state=0 and phase_done=0 before the next clk edge; after release, first green is G1, with demand cleared.

Source files
------------

// File: rtl/traffic_phase_controller_pkg.sv
// Shared phase encoding and road helpers for the junction sequencer and the lamp decoder.
package traffic_phase_controller_pkg;
   localparam int ROADS = 4;

   typedef logic [1:0] road_t;
   typedef logic [3:0] phase_t;

   localparam phase_t PH_ALL_RED = 4'd0;
   localparam phase_t PH_G1      = 4'd1;
   localparam phase_t PH_Y1      = 4'd2;
   localparam phase_t PH_G2      = 4'd3;
   localparam phase_t PH_Y2      = 4'd4;
   localparam phase_t PH_G3      = 4'd5;
   localparam phase_t PH_Y3      = 4'd6;
   localparam phase_t PH_G4      = 4'd7;
   localparam phase_t PH_Y4      = 4'd8;

   function automatic logic is_green(phase_t p);
      return p inside {PH_G1, PH_G2, PH_G3, PH_G4};
   endfunction

   function automatic logic is_yellow(phase_t p);
      return p inside {PH_Y1, PH_Y2, PH_Y3, PH_Y4};
   endfunction

   // Road index 0..3 maps to green code 2r+1 and yellow code 2r+2.
   function automatic phase_t green_of(road_t r);
      return phase_t'({r, 1'b1});
   endfunction

   function automatic road_t road_of(phase_t p);
      return road_t'((p - 4'd1) >> 1);
   endfunction
endpackage

// File: rtl/traffic_phase_controller_rr_road_arbiter.sv
// Round-robin road picker: nearest requesting road after the last served one.
module rr_road_arbiter
   import traffic_phase_controller_pkg::*;
(
   input  logic [ROADS-1:0] i_demand,
   input  road_t            i_last,
   output road_t            o_winner,
   output logic             o_any
);
   always_comb begin
      road_t v_cand;
      o_winner = '0;
      o_any    = |i_demand;
      // Walk from farthest to nearest so the nearest requester overwrites.
      for (int k = ROADS; k >= 1; k--) begin
         v_cand = i_last + road_t'(k);
         if (i_demand[v_cand]) o_winner = v_cand;
      end
   end
endmodule

// File: rtl/traffic_phase_controller.sv
// Junction phase sequencer: arbitrates road service and times green/yellow/clearance phases.
module traffic_phase_controller
   import traffic_phase_controller_pkg::*;
#(
   parameter int unsigned GREEN_MIN = 4,
   parameter int unsigned GREEN_MAX = 10,
   parameter int unsigned YELLOW_T  = 2,
   parameter int unsigned CLEAR_T   = 1,
   parameter int unsigned TIMER_W   = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick_en,
   input  logic       a,
   input  logic       b,
   input  logic       c,
   input  logic       d,
   output logic [3:0] state,
   output logic [3:0] next_state,
   output logic       phase_done
);
   if (GREEN_MIN > GREEN_MAX || GREEN_MIN == 0 || YELLOW_T == 0 || CLEAR_T == 0 ||
       TIMER_W > 31 || GREEN_MAX >= (1 << TIMER_W)) begin : g_bad_params
      $error("traffic_phase_controller: illegal timing parameters");
   end

   localparam logic [TIMER_W-1:0] GMIN_LIM = TIMER_W'(GREEN_MIN - 1);
   localparam logic [TIMER_W-1:0] GMAX_LIM = TIMER_W'(GREEN_MAX - 1);
   localparam logic [TIMER_W-1:0] Y_LIM    = TIMER_W'(YELLOW_T - 1);
   localparam logic [TIMER_W-1:0] C_LIM    = TIMER_W'(CLEAR_T - 1);

   phase_t             r_state;
   logic [TIMER_W-1:0] r_timer;
   logic [ROADS-1:0]   r_demand;
   road_t              r_last;
   logic               r_done;

   logic [ROADS-1:0]   w_sensor, w_own_mask, w_clr;
   road_t              w_own, w_winner, w_target;
   logic               w_any, w_green, w_yellow, w_illegal, w_other, w_exit, w_trans;
   phase_t             w_next;

   assign w_sensor   = {d, c, b, a};
   assign w_green    = is_green(r_state);
   assign w_yellow   = is_yellow(r_state);
   assign w_illegal  = r_state > PH_Y4;
   assign w_own      = road_of(r_state);
   assign w_own_mask = ROADS'(1) << w_own;
   assign w_other    = |(r_demand & ~w_own_mask);

   // Live sensors feed arbitration so next_state tracks them during clearance.
   rr_road_arbiter u_arb (
      .i_demand (r_demand | w_sensor),
      .i_last   (r_last),
      .o_winner (w_winner),
      .o_any    (w_any)
   );

   assign w_target = w_any ? w_winner : r_last + 2'd1;
   assign w_trans  = (tick_en & w_exit) | w_illegal;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= PH_ALL_RED;
      else if (w_trans) r_state <= w_next;
   end

   always_comb begin
      w_next = PH_ALL_RED;
      w_exit = 1'b0;
      if (w_green) begin
         w_next = r_state + 4'd1;
         w_exit = w_other && (r_timer >= GMAX_LIM ||
                  (r_timer >= GMIN_LIM && !w_sensor[w_own]));
      end else if (w_yellow) begin
         w_exit = r_timer == Y_LIM;
      end else if (r_state == PH_ALL_RED) begin
         w_next = green_of(w_target);
         w_exit = r_timer == C_LIM;
      end
   end

   always_comb begin
      state      = r_state;
      next_state = w_next;
      phase_done = r_done;
   end

   // Serving road's demand is held clear for the whole green, starting at the entry edge.
   assign w_clr = (w_green ? w_own_mask : '0) |
                  ((w_trans && r_state == PH_ALL_RED) ? ROADS'(1) << w_target : '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_timer  <= '0;
         r_demand <= '0;
         r_last   <= 2'd3;
         r_done   <= 1'b0;
      end else begin
         r_done   <= w_trans;
         r_demand <= (r_demand | w_sensor) & ~w_clr;
         if (w_trans) r_timer <= '0;
         else if (tick_en && r_timer != '1) r_timer <= r_timer + 1'b1;
         if (w_trans && r_state == PH_ALL_RED) r_last <= w_target;
      end
   end
endmodule
